alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Master-side driver for ALU_32. It accepts operation requests (Control code, A, B) over a valid/ready handshake and drives the ALU's reg_A, reg_B and Control inputs. It waits the ALU's op-dependent latency, captures the 64-bit reg_C result and returns it over a valid/ready response channel. Results of multiply and divide ops are also kept in architectural HI/LO registers for the core's datapath.

Parameters:
SIMPLE_LAT, 1, ALU cycles for non-mul/div ops; legal range 1..15.
MULDIV_LAT, 4, ALU cycles for MUL_OP/DIV_OP; legal range 1..15.
MUL_OP, 5'b01110, Control code for multiply.
DIV_OP, 5'b01111, Control code for divide.

Ports:
Clock  in  1  system clock; all logic on rising edge.
Clear  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  sequencer can accept a request.
req_op  in  5  ALU Control code.
req_a  in  32  operand A.
req_b  in  32  operand B.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer takes result.
rsp_data  out  64  captured reg_C.
rsp_op  out  5  op code of the returned result.
alu_A  out  32  to ALU reg_A.
alu_B  out  32  to ALU reg_B.
alu_Control  out  5  to ALU Control.
alu_C  in  64  from ALU reg_C.
hi  out  32  upper word of last mul/div result.
lo  out  32  lower word of last mul/div result.
busy  out  1  state != IDLE.

Behaviour:
- Reset (Clear high at an edge): state=IDLE. alu_A, alu_B, alu_Control, rsp_data, rsp_op, hi, lo all 0. rsp_valid=0, busy=0. Clear overrides every other input, including mid-operation; an in-flight op is dropped and no response is produced.
- req_ready = (state==IDLE) && !Clear, combinational. rsp_valid, rsp_data, rsp_op, hi, lo, busy and the alu_* outputs are all registered.
- States: IDLE, WAIT, RESP.
- IDLE: on an edge with req_valid&&req_ready, register req_a, req_b and req_op into alu_A, alu_B, alu_Control. Load cnt = MULDIV_LAT if req_op is MUL_OP or DIV_OP, otherwise SIMPLE_LAT. Go to WAIT.
- WAIT: alu_* are held stable. On each edge with cnt!=0, decrement cnt. On the edge where cnt==0:
  - rsp_data <= alu_C, rsp_op <= alu_Control, rsp_valid <= 1.
  - If the op is mul/div: hi <= alu_C[63:32], lo <= alu_C[31:0].
  - Go to RESP.
- Latency: an accept at edge N gives rsp_valid high after edge N+LAT+1. For SIMPLE_LAT=1 that is N+2.
- RESP: rsp_data and rsp_op are held until rsp_valid&&rsp_ready at an edge. That edge clears rsp_valid and returns to IDLE. The earliest next accept is the following edge, so peak throughput is one op per LAT+3 cycles.
- alu_* keep their last values in IDLE and RESP; they are not zeroed between ops.
- Non-mul/div ops never modify hi/lo. The result is not interpreted, so a divide by zero is passed through as whatever the ALU returns.
- req_valid while not ready is ignored. The requester must hold its request until accepted.
- cnt is 4 bits. Any parameter value outside 1..15 is an elaboration error.

Optional Feature:
ALU_SEQ_PERF_EN
- Defined: adds output op_count[31:0] and output busy_cycles[31:0], both reset to 0 by Clear.
  - op_count increments on each response handshake.
  - busy_cycles increments on every edge where busy==1.
  - Both wrap modulo 2^32.
- Undefined: neither port nor either counter exists. All other behaviour is identical.

Test Plan:
1. Clear for 2 edges, then release -> every output is 0, req_ready=1, busy=0.
2. Add op 5'b00000, A=4, B=4, accepted at edge N, rsp_ready=1 -> rsp_valid rises after edge N+2 with rsp_data=64'h8, rsp_op=0. Then sub op 5'b00001 with the same operands -> rsp_data=0. hi and lo remain 0 throughout.
3. MUL_OP, A=32'h0001_0000, B=32'h0001_0000, MULDIV_LAT=4 -> rsp_valid after edge N+5 with rsp_data=64'h0000_0001_0000_0000, hi=1, lo=0.
4. rsp_ready held 0 for 5 cycles after a result arrives -> rsp_data stays stable, req_ready=0, and a new req_valid is not accepted. Raising rsp_ready then completes the handshake, and the request is accepted on the next edge.
5. Clear asserted during WAIT of a MUL_OP -> no response is produced, state returns to IDLE, and hi/lo=0. A subsequent add 2+3 returns 5.
6. With ALU_SEQ_PERF_EN, run 3 ops -> op_count=3, and busy_cycles equals the sum of the per-op busy cycles from the testbench's cycle count.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: master-side driver for ALU_32.
// Accepts (op, A, B) requests, holds them on the ALU inputs for the
// op-dependent latency, captures reg_C, and returns it over a valid/ready
// response channel. Multiply/divide results are also kept in HI/LO.
// Optional feature macro: ALU_SEQ_PERF_EN adds op_count and busy_cycles.
module alu_op_sequencer #(
  parameter int         SIMPLE_LAT = 1,
  parameter int         MULDIV_LAT = 4,
  parameter logic [4:0] MUL_OP     = 5'b01110,
  parameter logic [4:0] DIV_OP     = 5'b01111
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [4:0]  rsp_op,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [4:0]  alu_Control,
  input  logic [63:0] alu_C,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0] op_count,
  output logic [31:0] busy_cycles
`endif
);

  // The wait counter is 4 bits wide, so both latencies must fit in 1..15.
  generate
    if (SIMPLE_LAT < 1 || SIMPLE_LAT > 15) begin : g_bad_simple_lat
      $error("alu_op_sequencer: SIMPLE_LAT must be in 1..15");
    end
    if (MULDIV_LAT < 1 || MULDIV_LAT > 15) begin : g_bad_muldiv_lat
      $error("alu_op_sequencer: MULDIV_LAT must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] SIMPLE_CNT = 4'(SIMPLE_LAT);
  localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       accept;
  logic       rsp_fire;
  logic       req_is_muldiv;
  logic       alu_is_muldiv;

  // State register; busy is registered from the next state so it tracks
  // state != IDLE without any combinational path to the output.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, drain in RESP.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (accept) state_next = S_WAIT;
      S_WAIT: if (cnt == 4'd0) state_next = S_RESP;
      S_RESP: if (rsp_fire) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Combinational outputs and handshake qualifiers.
  always_comb begin
    req_ready     = (state == S_IDLE) && !Clear;
    accept        = req_valid && req_ready;
    rsp_fire      = rsp_valid && rsp_ready;
    req_is_muldiv = (req_op == MUL_OP) || (req_op == DIV_OP);
    alu_is_muldiv = (alu_Control == MUL_OP) || (alu_Control == DIV_OP);
  end

  // Datapath: latch the request onto the ALU, wait out its latency, then
  // capture reg_C into the response (and HI/LO for mul/div).
  always_ff @(posedge Clock) begin
    if (Clear) begin
      alu_A       <= 32'd0;
      alu_B       <= 32'd0;
      alu_Control <= 5'd0;
      cnt         <= 4'd0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 64'd0;
      rsp_op      <= 5'd0;
      hi          <= 32'd0;
      lo          <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            alu_A       <= req_a;
            alu_B       <= req_b;
            alu_Control <= req_op;
            cnt         <= req_is_muldiv ? MULDIV_CNT : SIMPLE_CNT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data  <= alu_C;
            rsp_op    <= alu_Control;
            rsp_valid <= 1'b1;
            if (alu_is_muldiv) begin
              hi <= alu_C[63:32];
              lo <= alu_C[31:0];
            end
          end
        end
        S_RESP: begin
          if (rsp_fire) rsp_valid <= 1'b0;
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // Performance counters: completed responses and cycles spent non-idle.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      op_count    <= 32'd0;
      busy_cycles <= 32'd0;
    end else begin
      if (rsp_fire) op_count <= op_count + 32'd1;
      if (busy) busy_cycles <= busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer with a
// behavioural ALU_32 model on the alu_* side.
// Exercises the ALU_SEQ_PERF_EN counters when that macro is defined.
module tb_alu_op_sequencer;

  localparam int         SIMPLE_LAT = 1;
  localparam int         MULDIV_LAT = 4;
  localparam logic [4:0] MUL_OP     = 5'b01110;
  localparam logic [4:0] DIV_OP     = 5'b01111;
  localparam logic [4:0] ADD_OP     = 5'b00000;
  localparam logic [4:0] SUB_OP     = 5'b00001;
  localparam logic [4:0] AND_OP     = 5'b00010;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [4:0]  rsp_op;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [4:0]  alu_Control;
  logic [63:0] alu_C;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] op_count;
  logic [31:0] busy_cycles;
`endif

  int vectors_applied = 0;
  int miscompares     = 0;
  int edge_count      = 0;

  logic [68:0] exp_q[$];
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  alu_op_sequencer #(
    .SIMPLE_LAT(SIMPLE_LAT),
    .MULDIV_LAT(MULDIV_LAT),
    .MUL_OP    (MUL_OP),
    .DIV_OP    (DIV_OP)
  ) dut (
    .Clock      (Clock),
    .Clear      (Clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_Control(alu_Control),
    .alu_C      (alu_C),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy)
`ifdef ALU_SEQ_PERF_EN
    ,
    .op_count   (op_count),
    .busy_cycles(busy_cycles)
`endif
  );

  // Free-running clock and rising-edge counter (edge N is visible at the
  // following falling edge as edge_count == N).
  always #5 Clock = ~Clock;
  always @(posedge Clock) edge_count <= edge_count + 1;

  // Behavioural ALU_32; divide by zero returns {A, all-ones}.
  function automatic logic [63:0] alu_model(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] r;
    case (op)
      ADD_OP:  r = {32'd0, a + b};
      SUB_OP:  r = {32'd0, a - b};
      AND_OP:  r = {32'd0, a & b};
      MUL_OP:  r = {32'd0, a} * {32'd0, b};
      DIV_OP:  r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: r = {32'd0, a ^ b};
    endcase
    return r;
  endfunction

  always_comb alu_C = alu_model(alu_Control, alu_A, alu_B);

  // Hard stop so a hung handshake can never stall the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one request and wait (bounded) for it to be taken.
  // Returns at the falling edge after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int acc_edge, output bit ok);
    ok = 1'b0;
    acc_edge = -1;
    @(negedge Clock);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (req_ready) begin
        @(posedge Clock);
        ok = 1'b1;
        exp_q.push_back({op, alu_model(op, a, b)});
      end
      @(negedge Clock);
    end
    req_valid = 1'b0;
    if (ok) acc_edge = edge_count;
  endtask

  // Wait (bounded) at falling edges for rsp_valid and report what was seen.
  task automatic wait_rsp(output bit seen, output int rsp_edge,
                          output logic [63:0] d, output logic [4:0] op);
    seen = 1'b0;
    rsp_edge = -1;
    d = '0;
    op = '0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        rsp_edge = edge_count;
        d = rsp_data;
        op = rsp_op;
      end else begin
        @(negedge Clock);
      end
    end
  endtask

  function automatic logic [68:0] pop_expected();
    if (exp_q.size() == 0) return '1;
    return exp_q.pop_front();
  endfunction

  // Two Clear edges, then every registered output must read zero.
  task automatic test_reset();
    Clear = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    @(negedge Clock);
    @(negedge Clock);
    vectors_applied++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ready_during_clear: got %b expected 0", req_ready);
    end
    Clear = 1'b0;
    #1;
    vectors_applied++;
    if ({rsp_valid, rsp_data, rsp_op, alu_A, alu_B, alu_Control, hi, lo, busy} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%h op=%h A=%h B=%h C=%h hi=%h lo=%h busy=%b expected all zero",
               rsp_valid, rsp_data, rsp_op, alu_A, alu_B, alu_Control, hi, lo, busy);
    end
    vectors_applied++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got %b expected 1", req_ready);
    end
  endtask

  // Add then sub on 4,4; single-cycle latency and HI/LO untouched.
  task automatic test_simple_ops();
    int acc, re;
    bit ok, seen;
    logic [63:0] d;
    logic [4:0] op;
    logic [68:0] exp;
    rsp_ready = 1'b1;
    issue(ADD_OP, 32'd4, 32'd4, acc, ok);
    wait_rsp(seen, re, d, op);
    exp = pop_expected();
    vectors_applied++;
    if (!ok || !seen || d !== exp[63:0] || op !== exp[68:64]) begin
      miscompares++;
      $display("[TB] FAIL add_result: got seen=%b d=%h op=%h expected d=%h op=%h", seen, d, op, exp[63:0], exp[68:64]);
    end
    vectors_applied++;
    if (d !== 64'h8) begin
      miscompares++;
      $display("[TB] FAIL add_value: got %h expected 0000000000000008", d);
    end
    vectors_applied++;
    if (re !== acc + SIMPLE_LAT + 1) begin
      miscompares++;
      $display("[TB] FAIL add_latency: got edge %0d expected edge %0d", re, acc + SIMPLE_LAT + 1);
    end
    @(negedge Clock);
    vectors_applied++;
    if ({hi, lo} !== 64'd0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_after: got hi=%h lo=%h v=%b busy=%b expected 0 0 0 0", hi, lo, rsp_valid, busy);
    end
    issue(SUB_OP, 32'd4, 32'd4, acc, ok);
    wait_rsp(seen, re, d, op);
    exp = pop_expected();
    vectors_applied++;
    if (!ok || !seen || d !== exp[63:0] || op !== exp[68:64] || d !== 64'd0 || op !== SUB_OP) begin
      miscompares++;
      $display("[TB] FAIL sub_result: got seen=%b d=%h op=%h expected d=%h op=%h", seen, d, op, exp[63:0], exp[68:64]);
    end
    vectors_applied++;
    if ({hi, lo} !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL sub_hilo: got %h expected 0", {hi, lo});
    end
    @(negedge Clock);
  endtask

  // Multiply with the long latency; HI/LO capture the product.
  task automatic test_mul();
    int acc, re;
    bit ok, seen;
    logic [63:0] d;
    logic [4:0] op;
    logic [68:0] exp;
    rsp_ready = 1'b1;
    issue(MUL_OP, 32'h0001_0000, 32'h0001_0000, acc, ok);
    wait_rsp(seen, re, d, op);
    exp = pop_expected();
    exp_hi = exp[63:32];
    exp_lo = exp[31:0];
    vectors_applied++;
    if (!ok || !seen || d !== exp[63:0] || op !== exp[68:64] || d !== 64'h0000_0001_0000_0000) begin
      miscompares++;
      $display("[TB] FAIL mul_result: got seen=%b d=%h op=%h expected d=0000000100000000 op=%h", seen, d, op, MUL_OP);
    end
    vectors_applied++;
    if (re !== acc + MULDIV_LAT + 1) begin
      miscompares++;
      $display("[TB] FAIL mul_latency: got edge %0d expected edge %0d", re, acc + MULDIV_LAT + 1);
    end
    vectors_applied++;
    if (hi !== 32'd1 || lo !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL mul_hilo: got hi=%h lo=%h expected hi=1 lo=0", hi, lo);
    end
    @(negedge Clock);
  endtask

  // Hold rsp_ready low with a competing request pending; release and the
  // pending request must be taken on the edge right after the handshake.
  task automatic test_backpressure();
    int acc, re, hs, acc2;
    bit ok, seen;
    logic [63:0] d, held;
    logic [4:0] op;
    logic [68:0] exp;
    int bad;
    rsp_ready = 1'b0;
    issue(SUB_OP, 32'd10, 32'd3, acc, ok);
    wait_rsp(seen, re, d, op);
    exp = pop_expected();
    vectors_applied++;
    if (!ok || !seen || d !== exp[63:0] || op !== exp[68:64]) begin
      miscompares++;
      $display("[TB] FAIL bp_result: got seen=%b d=%h op=%h expected d=%h op=%h", seen, d, op, exp[63:0], exp[68:64]);
    end
    held = d;
    req_valid = 1'b1;
    req_op = AND_OP;
    req_a = 32'h0000_F0F0;
    req_b = 32'h0000_0FF0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      if (rsp_data !== held || rsp_valid !== 1'b1 || req_ready !== 1'b0 || alu_A !== 32'd10) bad++;
    end
    vectors_applied++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_stall: got %0d bad stall cycles (last d=%h v=%b rdy=%b A=%h) expected 0", bad, rsp_data, rsp_valid, req_ready, alu_A);
    end
    rsp_ready = 1'b1;
    @(negedge Clock);
    hs = edge_count;
    vectors_applied++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", rsp_valid, req_ready);
    end
    if (req_ready) exp_q.push_back({AND_OP, alu_model(AND_OP, req_a, req_b)});
    @(negedge Clock);
    acc2 = edge_count;
    req_valid = 1'b0;
    vectors_applied++;
    if (busy !== 1'b1 || alu_A !== 32'h0000_F0F0 || alu_Control !== AND_OP || acc2 !== hs + 1) begin
      miscompares++;
      $display("[TB] FAIL bp_next_accept: got busy=%b A=%h C=%h edge=%0d expected busy=1 A=0000f0f0 C=%h edge=%0d",
               busy, alu_A, alu_Control, acc2, AND_OP, hs + 1);
    end
    wait_rsp(seen, re, d, op);
    exp = pop_expected();
    vectors_applied++;
    if (!seen || d !== exp[63:0] || op !== exp[68:64]) begin
      miscompares++;
      $display("[TB] FAIL bp_second_result: got seen=%b d=%h op=%h expected d=%h op=%h", seen, d, op, exp[63:0], exp[68:64]);
    end
    @(negedge Clock);
  endtask

  // Clear during a multiply's WAIT drops it; a following add still works.
  task automatic test_clear_mid_op();
    int acc, re, stray;
    bit ok, seen;
    logic [63:0] d;
    logic [4:0] op;
    logic [68:0] exp;
    rsp_ready = 1'b1;
    issue(MUL_OP, 32'd3, 32'd5, acc, ok);
    if (ok) void'(exp_q.pop_back());
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    vectors_applied++;
    if (!ok || hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clear_state: got ok=%b hi=%h lo=%h busy=%b v=%b rdy=%b expected 1 0 0 0 0 1",
               ok, hi, lo, busy, rsp_valid, req_ready);
    end
    stray = 0;
    for (int i = 0; i < MULDIV_LAT + 4; i++) begin
      @(negedge Clock);
      if (rsp_valid !== 1'b0) stray++;
    end
    vectors_applied++;
    if (stray != 0) begin
      miscompares++;
      $display("[TB] FAIL clear_no_rsp: got %0d cycles with rsp_valid expected 0", stray);
    end
    issue(ADD_OP, 32'd2, 32'd3, acc, ok);
    wait_rsp(seen, re, d, op);
    exp = pop_expected();
    vectors_applied++;
    if (!ok || !seen || d !== exp[63:0] || d !== 64'd5 || op !== ADD_OP) begin
      miscompares++;
      $display("[TB] FAIL clear_then_add: got seen=%b d=%h op=%h expected d=5 op=0", seen, d, op);
    end
    @(negedge Clock);
  endtask

  // Back-to-back ops at peak rate, including divide by zero and an add that
  // wraps; checks accept spacing of LAT+3 and HI/LO only moving on mul/div.
  task automatic test_back_to_back();
    logic [4:0]  ops[3];
    logic [31:0] as[3];
    logic [31:0] bs[3];
    int acc, prev_acc, prev_lat, re;
    bit ok, seen;
    logic [63:0] d;
    logic [4:0] op;
    logic [68:0] exp;
    ops = '{AND_OP, DIV_OP, ADD_OP};
    as  = '{32'hDEAD_BEEF, 32'd77, 32'd1};
    bs  = '{32'hFFFF_0000, 32'd0, 32'hFFFF_FFFF};
    rsp_ready = 1'b1;
    prev_acc = -1;
    prev_lat = 0;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i], acc, ok);
      vectors_applied++;
      if (!ok || (prev_acc >= 0 && acc !== prev_acc + prev_lat + 3)) begin
        miscompares++;
        $display("[TB] FAIL b2b_spacing_%0d: got accept edge %0d expected %0d", i, acc, prev_acc + prev_lat + 3);
      end
      wait_rsp(seen, re, d, op);
      exp = pop_expected();
      if (exp[68:64] == MUL_OP || exp[68:64] == DIV_OP) begin
        exp_hi = exp[63:32];
        exp_lo = exp[31:0];
      end
      vectors_applied++;
      if (!seen || d !== exp[63:0] || op !== exp[68:64]) begin
        miscompares++;
        $display("[TB] FAIL b2b_result_%0d: got seen=%b d=%h op=%h expected d=%h op=%h", i, seen, d, op, exp[63:0], exp[68:64]);
      end
      vectors_applied++;
      if (hi !== exp_hi || lo !== exp_lo) begin
        miscompares++;
        $display("[TB] FAIL b2b_hilo_%0d: got hi=%h lo=%h expected hi=%h lo=%h", i, hi, lo, exp_hi, exp_lo);
      end
      prev_acc = acc;
      prev_lat = (ops[i] == MUL_OP || ops[i] == DIV_OP) ? MULDIV_LAT : SIMPLE_LAT;
    end
    vectors_applied++;
    if (hi !== 32'd77 || lo !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("[TB] FAIL b2b_div0_hilo: got hi=%h lo=%h expected hi=0000004d lo=ffffffff", hi, lo);
    end
    @(negedge Clock);
  endtask

`ifdef ALU_SEQ_PERF_EN
  // Three ops after a Clear: op_count is 3 and busy_cycles equals the sum
  // of edges from each accept to its response handshake.
  task automatic test_perf();
    logic [4:0]  ops[3];
    int acc, re, exp_busy;
    bit ok, seen;
    logic [63:0] d;
    logic [4:0] op;
    logic [68:0] exp;
    ops = '{ADD_OP, MUL_OP, SUB_OP};
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    vectors_applied++;
    if (op_count !== 32'd0 || busy_cycles !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL perf_reset: got ops=%0d busy=%0d expected 0 0", op_count, busy_cycles);
    end
    rsp_ready = 1'b1;
    exp_busy = 0;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'd6 + 32'(i), 32'd2, acc, ok);
      wait_rsp(seen, re, d, op);
      exp = pop_expected();
      vectors_applied++;
      if (!ok || !seen || d !== exp[63:0]) begin
        miscompares++;
        $display("[TB] FAIL perf_result_%0d: got seen=%b d=%h expected %h", i, seen, d, exp[63:0]);
      end
      exp_busy += (re + 1) - acc;
      @(negedge Clock);
    end
    vectors_applied++;
    if (op_count !== 32'd3) begin
      miscompares++;
      $display("[TB] FAIL perf_op_count: got %0d expected 3", op_count);
    end
    vectors_applied++;
    if (busy_cycles !== 32'(exp_busy)) begin
      miscompares++;
      $display("[TB] FAIL perf_busy_cycles: got %0d expected %0d", busy_cycles, exp_busy);
    end
  endtask
`endif

  // Test sequence.
  initial begin
    Clear = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_simple_ops();
    test_mul();
    test_backpressure();
    test_clear_mid_op();
    test_back_to_back();
`ifdef ALU_SEQ_PERF_EN
    test_perf();
`endif
    vectors_applied++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
